// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - main control FSM of the multicycle MIPS datapath
//
// Sequences one instruction at a time through fetch, decode, execute, memory
// and write-back, and drives every datapath select from the registered state.
// Optional feature macro: MC_CTRL_ADDI_EN (adds the ADDI_EX/ADDI_WB path).
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   opcode[5:0]         instruction register bits [31:26]
//   zero                ALU zero flag (used by the datapath together with pcwritecond)
//   mem_ready           memory access presented this cycle completes this cycle
//   pcwrite, pcwritecond, iord, memread, memwrite, irwrite   PC/memory/IR controls
//   memtoreg, regdst, regwrite                              register-file write-back
//   alusrca, alusrcb[1:0], aluop[1:0], pcsource[1:0]        datapath selects
//   state[3:0]          current state encoding (debug)
//   illegal             an unsupported opcode was decoded; held until reset
//   instr_retired       count of completed instructions, wraps to 0

module multicycle_control #(
    parameter int RETIRE_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [5:0]          opcode,
    input  logic                zero,
    input  logic                mem_ready,
    output logic                pcwrite,
    output logic                pcwritecond,
    output logic                iord,
    output logic                memread,
    output logic                memwrite,
    output logic                irwrite,
    output logic                memtoreg,
    output logic                regdst,
    output logic                regwrite,
    output logic                alusrca,
    output logic [1:0]          alusrcb,
    output logic [1:0]          aluop,
    output logic [1:0]          pcsource,
    output logic [3:0]          state,
    output logic                illegal,
    output logic [RETIRE_W-1:0] instr_retired
);

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECUTE  = 4'd6;
    localparam logic [3:0] S_RTYPE_WB = 4'd7;
    localparam logic [3:0] S_BRANCH   = 4'd8;
    localparam logic [3:0] S_JUMP     = 4'd9;
    localparam logic [3:0] S_ADDI_EX  = 4'd10;
    localparam logic [3:0] S_ADDI_WB  = 4'd11;
    localparam logic [3:0] S_ILLEGAL  = 4'd15;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    logic [3:0] next_state;
    logic       retire;

    // The branch decision itself is made in the datapath (pcwritecond & zero).
    logic unused_zero;
    assign unused_zero = zero;

    always_comb begin
        next_state = state;
        case (state)
            S_FETCH:    if (mem_ready) next_state = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:      next_state = S_EXECUTE;
                    OP_LW, OP_SW:  next_state = S_MEMADR;
                    OP_BEQ:        next_state = S_BRANCH;
                    OP_J:          next_state = S_JUMP;
`ifdef MC_CTRL_ADDI_EN
                    OP_ADDI:       next_state = S_ADDI_EX;
`endif
                    default:       next_state = S_ILLEGAL;
                endcase
            end
            S_MEMADR: begin
                // The IR holds the opcode, so it is still lw or sw here.
                if (opcode == OP_LW)      next_state = S_MEMREAD;
                else if (opcode == OP_SW) next_state = S_MEMWRITE;
                else                      next_state = S_ILLEGAL;
            end
            S_MEMREAD:  if (mem_ready) next_state = S_MEMWB;
            S_MEMWRITE: if (mem_ready) next_state = S_FETCH;
            S_MEMWB:    next_state = S_FETCH;
            S_EXECUTE:  next_state = S_RTYPE_WB;
            S_RTYPE_WB: next_state = S_FETCH;
            S_BRANCH:   next_state = S_FETCH;
            S_JUMP:     next_state = S_FETCH;
`ifdef MC_CTRL_ADDI_EN
            S_ADDI_EX:  next_state = S_ADDI_WB;
            S_ADDI_WB:  next_state = S_FETCH;
`endif
            S_ILLEGAL:  next_state = S_ILLEGAL;
            // Unused encodings are treated as a decode fault.
            default:    next_state = S_ILLEGAL;
        endcase
    end

    always_comb begin
        retire = 1'b0;
        case (state)
            S_MEMWB, S_RTYPE_WB, S_BRANCH, S_JUMP: retire = 1'b1;
`ifdef MC_CTRL_ADDI_EN
            S_ADDI_WB:                             retire = 1'b1;
`endif
            S_MEMWRITE:                            retire = mem_ready;
            default:                               retire = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_FETCH;
            instr_retired <= '0;
        end else begin
            state <= next_state;
            if (retire) instr_retired <= instr_retired + 1'b1;
        end
    end

    // Register-file write controls depend on state bits only so the
    // combinational register file never sees a glitch from mem_ready/opcode.
    // Reset forces state to FETCH, where all three are already 0.
    always_comb begin
        regwrite = (state == S_MEMWB) || (state == S_RTYPE_WB)
`ifdef MC_CTRL_ADDI_EN
                   || (state == S_ADDI_WB)
`endif
                   ;
        regdst   = (state == S_RTYPE_WB);
        memtoreg = (state == S_MEMWB);
    end

    assign illegal = (state == S_ILLEGAL);

    always_comb begin
        pcwrite     = 1'b0;
        pcwritecond = 1'b0;
        iord        = 1'b0;
        memread     = 1'b0;
        memwrite    = 1'b0;
        irwrite     = 1'b0;
        alusrca     = 1'b0;
        alusrcb     = 2'b00;
        aluop       = 2'b00;
        pcsource    = 2'b00;
        case (state)
            S_FETCH: begin
                memread = 1'b1;
                alusrcb = 2'b01;
                irwrite = mem_ready;
                pcwrite = mem_ready;
            end
            S_DECODE:   alusrcb = 2'b11;
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_MEMREAD: begin
                memread = 1'b1;
                iord    = 1'b1;
            end
            S_MEMWRITE: begin
                memwrite = 1'b1;
                iord     = 1'b1;
            end
            S_EXECUTE: begin
                alusrca = 1'b1;
                aluop   = 2'b10;
            end
            S_BRANCH: begin
                alusrca     = 1'b1;
                aluop       = 2'b01;
                pcwritecond = 1'b1;
                pcsource    = 2'b01;
            end
            S_JUMP: begin
                pcwrite  = 1'b1;
                pcsource = 2'b10;
            end
`ifdef MC_CTRL_ADDI_EN
            S_ADDI_EX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
`endif
            default: ;
        endcase
        // FETCH would otherwise drive memread/alusrcb while reset is held.
        if (rst) begin
            pcwrite     = 1'b0;
            pcwritecond = 1'b0;
            iord        = 1'b0;
            memread     = 1'b0;
            memwrite    = 1'b0;
            irwrite     = 1'b0;
            alusrca     = 1'b0;
            alusrcb     = 2'b00;
            aluop       = 2'b00;
            pcsource    = 2'b00;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - directed self-checking bench for multicycle_control

module tb_multicycle_control;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  opcode = 6'd0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b1;
    logic        pcwrite, pcwritecond, iord, memread, memwrite, irwrite;
    logic        memtoreg, regdst, regwrite, alusrca;
    logic [1:0]  alusrcb, aluop, pcsource;
    logic [3:0]  state;
    logic        illegal;
    logic [15:0] instr_retired;

    logic [15:0] ctl;
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] exp_ret = 16'd0;

    multicycle_control #(.RETIRE_W(16)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pcwrite(pcwrite), .pcwritecond(pcwritecond), .iord(iord), .memread(memread),
        .memwrite(memwrite), .irwrite(irwrite), .memtoreg(memtoreg), .regdst(regdst),
        .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb), .aluop(aluop),
        .pcsource(pcsource), .state(state), .illegal(illegal), .instr_retired(instr_retired)
    );

    always #5 clk = ~clk;

    // {pcwrite,pcwritecond,iord,memread,memwrite,irwrite,memtoreg,regdst,regwrite,
    //  alusrca,alusrcb[1:0],aluop[1:0],pcsource[1:0]}
    assign ctl = {pcwrite, pcwritecond, iord, memread, memwrite, irwrite, memtoreg,
                  regdst, regwrite, alusrca, alusrcb, aluop, pcsource};

    task automatic test_reset();
        @(negedge clk); #1;
        n_tests++;
        if (state !== 4'd0) begin n_fail++; $display("FAIL reset_state got %0d want 0", state); end
        n_tests++;
        if (ctl !== 16'h0000) begin n_fail++; $display("FAIL reset_ctl got %h want 0000", ctl); end
        n_tests++;
        if (instr_retired !== 16'd0 || illegal !== 1'b0) begin
            n_fail++; $display("FAIL reset_cnt got ret=%0d ill=%b want 0/0", instr_retired, illegal);
        end
        rst = 1'b0;
        exp_ret = 16'd0;
    endtask

    task automatic test_lw();
        logic [3:0]  es [5] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
        logic [15:0] ec [5] = '{16'h9410, 16'h0030, 16'h0060, 16'h3000, 16'h0280};
        opcode = 6'b100011; mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_tests++;
            if (state !== es[i]) begin n_fail++; $display("FAIL lw_state step %0d got %0d want %0d", i, state, es[i]); end
            n_tests++;
            if (ctl !== ec[i]) begin n_fail++; $display("FAIL lw_ctl step %0d got %h want %h", i, ctl, ec[i]); end
            @(negedge clk); #1;
        end
        exp_ret = exp_ret + 16'd1;
        n_tests++;
        if (state !== 4'd0 || instr_retired !== exp_ret) begin
            n_fail++; $display("FAIL lw_retire got st=%0d ret=%0d want 0/%0d", state, instr_retired, exp_ret);
        end
    endtask

    task automatic test_rtype_stall();
        logic [3:0]  es [6] = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd6, 4'd7};
        logic [15:0] ec [6] = '{16'h1010, 16'h1010, 16'h9410, 16'h0030, 16'h0048, 16'h0180};
        logic        mr [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        opcode = 6'b000000;
        for (int i = 0; i < 6; i++) begin
            mem_ready = mr[i];
            #1;
            n_tests++;
            if (state !== es[i]) begin n_fail++; $display("FAIL rtype_state step %0d got %0d want %0d", i, state, es[i]); end
            n_tests++;
            if (ctl !== ec[i]) begin n_fail++; $display("FAIL rtype_ctl step %0d got %h want %h", i, ctl, ec[i]); end
            @(negedge clk); #1;
        end
        exp_ret = exp_ret + 16'd1;
        n_tests++;
        if (state !== 4'd0 || instr_retired !== exp_ret) begin
            n_fail++; $display("FAIL rtype_retire got st=%0d ret=%0d want 0/%0d", state, instr_retired, exp_ret);
        end
    endtask

    task automatic test_sw_stall();
        logic [3:0]  es [7] = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd5, 4'd5, 4'd5};
        logic [15:0] ec [7] = '{16'h9410, 16'h0030, 16'h0060, 16'h2800, 16'h2800, 16'h2800, 16'h2800};
        logic        mr [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        opcode = 6'b101011;
        for (int i = 0; i < 7; i++) begin
            mem_ready = mr[i];
            #1;
            n_tests++;
            if (state !== es[i]) begin n_fail++; $display("FAIL sw_state step %0d got %0d want %0d", i, state, es[i]); end
            n_tests++;
            if (ctl !== ec[i]) begin n_fail++; $display("FAIL sw_ctl step %0d got %h want %h", i, ctl, ec[i]); end
            n_tests++;
            if (i >= 3 && instr_retired !== exp_ret) begin
                n_fail++; $display("FAIL sw_stall_ret step %0d got %0d want %0d", i, instr_retired, exp_ret);
            end
            @(negedge clk); #1;
        end
        mem_ready = 1'b1;
        exp_ret = exp_ret + 16'd1;
        n_tests++;
        if (state !== 4'd0 || instr_retired !== exp_ret) begin
            n_fail++; $display("FAIL sw_retire got st=%0d ret=%0d want 0/%0d", state, instr_retired, exp_ret);
        end
    endtask

    task automatic test_beq_j();
        logic [3:0]  es [6] = '{4'd0, 4'd1, 4'd8, 4'd0, 4'd1, 4'd9};
        logic [15:0] ec [6] = '{16'h9410, 16'h0030, 16'h4045, 16'h9410, 16'h0030, 16'h8002};
        logic [5:0]  op [6] = '{6'b000100, 6'b000100, 6'b000100, 6'b000010, 6'b000010, 6'b000010};
        mem_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            opcode = op[i];
            zero = i[0];
            #1;
            n_tests++;
            if (state !== es[i]) begin n_fail++; $display("FAIL bj_state step %0d got %0d want %0d", i, state, es[i]); end
            n_tests++;
            if (ctl !== ec[i]) begin n_fail++; $display("FAIL bj_ctl step %0d got %h want %h", i, ctl, ec[i]); end
            @(negedge clk); #1;
        end
        exp_ret = exp_ret + 16'd2;
        n_tests++;
        if (state !== 4'd0 || instr_retired !== exp_ret) begin
            n_fail++; $display("FAIL bj_retire got st=%0d ret=%0d want 0/%0d", state, instr_retired, exp_ret);
        end
    endtask

    task automatic test_illegal();
        opcode = 6'b111111; mem_ready = 1'b1;
        @(negedge clk); #1;
        @(negedge clk); #1;
        opcode = 6'b000000;
        for (int i = 0; i < 20; i++) begin
            mem_ready = i[0];
            #1;
            n_tests++;
            if (state !== 4'd15 || illegal !== 1'b1) begin
                n_fail++; $display("FAIL ill_state cyc %0d got st=%0d ill=%b want 15/1", i, state, illegal);
            end
            n_tests++;
            if (ctl !== 16'h0000 || instr_retired !== exp_ret) begin
                n_fail++; $display("FAIL ill_ctl cyc %0d got ctl=%h ret=%0d want 0000/%0d", i, ctl, instr_retired, exp_ret);
            end
            @(negedge clk); #1;
        end
        rst = 1'b1; mem_ready = 1'b1;
        #1;
        n_tests++;
        if (state !== 4'd0 || illegal !== 1'b0 || instr_retired !== 16'd0 || ctl !== 16'h0000) begin
            n_fail++; $display("FAIL ill_reset got st=%0d ill=%b ret=%0d ctl=%h want 0/0/0/0000",
                               state, illegal, instr_retired, ctl);
        end
        @(negedge clk); #1;
        rst = 1'b0;
        exp_ret = 16'd0;
    endtask

    task automatic test_reset_mid_wb();
        opcode = 6'b100011; mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
        end
        n_tests++;
        if (state !== 4'd4 || regwrite !== 1'b1) begin
            n_fail++; $display("FAIL midwb_pre got st=%0d rw=%b want 4/1", state, regwrite);
        end
        rst = 1'b1;
        #1;
        n_tests++;
        if (regwrite !== 1'b0 || state !== 4'd0 || instr_retired !== 16'd0) begin
            n_fail++; $display("FAIL midwb_rst got rw=%b st=%0d ret=%0d want 0/0/0", regwrite, state, instr_retired);
        end
        @(negedge clk); #1;
        rst = 1'b0;
        exp_ret = 16'd0;
        #1;
        n_tests++;
        if (state !== 4'd0 || ctl !== 16'h9410) begin
            n_fail++; $display("FAIL midwb_after got st=%0d ctl=%h want 0/9410", state, ctl);
        end
    endtask

    task automatic test_addi();
`ifdef MC_CTRL_ADDI_EN
        logic [3:0]  es [5] = '{4'd0, 4'd1, 4'd10, 4'd11, 4'd0};
        logic [15:0] ec [5] = '{16'h9410, 16'h0030, 16'h0060, 16'h0080, 16'h9410};
`else
        logic [3:0]  es [5] = '{4'd0, 4'd1, 4'd15, 4'd15, 4'd15};
        logic [15:0] ec [5] = '{16'h9410, 16'h0030, 16'h0000, 16'h0000, 16'h0000};
`endif
        opcode = 6'b001000; mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_tests++;
            if (state !== es[i]) begin n_fail++; $display("FAIL addi_state step %0d got %0d want %0d", i, state, es[i]); end
            n_tests++;
            if (ctl !== ec[i]) begin n_fail++; $display("FAIL addi_ctl step %0d got %h want %h", i, ctl, ec[i]); end
            @(negedge clk); #1;
        end
`ifdef MC_CTRL_ADDI_EN
        exp_ret = exp_ret + 16'd1;
`endif
        n_tests++;
        if (instr_retired !== exp_ret) begin
            n_fail++; $display("FAIL addi_retire got %0d want %0d", instr_retired, exp_ret);
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_rtype_stall();
        test_sw_stall();
        test_beq_j();
        test_illegal();
        test_reset_mid_wb();
        test_addi();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
